// File: rtl/if_id_stage_reg_if.sv
// IF/ID pipeline register bundle: fetch-side controls and data in,
// registered instruction, decoded fields and stall status out.
interface if_id_stage_reg_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 4
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [ADDR_W-1:0] pc_i;
  logic [31:0]       inst_i;
  logic              valid_o;
  logic [ADDR_W-1:0] pc_o;
  logic [31:0]       inst_o;
  logic [5:0]        op_o;
  logic [4:0]        rs_o;
  logic [4:0]        rt_o;
  logic [4:0]        rd_o;
  logic [4:0]        shamt_o;
  logic [5:0]        funct_o;
  logic [15:0]       imm_o;
  logic [25:0]       jaddr_o;
  logic              held_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              stall_timeout_o;

  modport master (
    output stall_i, flush_i, valid_i, pc_i, inst_i,
    input  valid_o, pc_o, inst_o, op_o, rs_o, rt_o, rd_o,
    input  shamt_o, funct_o, imm_o, jaddr_o,
    input  held_o, stall_cnt_o, stall_timeout_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, pc_i, inst_i,
    output valid_o, pc_o, inst_o, op_o, rs_o, rt_o, rd_o,
    output shamt_o, funct_o, imm_o, jaddr_o,
    output held_o, stall_cnt_o, stall_timeout_o
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the 5-stage MIPS core with stall/flush,
// MIPS field decode and a sticky stall watchdog.
module if_id_stage_reg #(
  parameter int          ADDR_W        = 32,
  parameter logic [31:0] NOP_INST      = 32'h0,
  parameter int          STALL_LIMIT   = 15,
  parameter int          CNT_W         = 4,
  parameter bit          FLUSH_KEEP_PC = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  if_id_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    HELD
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);

  state_e            state_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       inst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              to_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      priority case (1'b1)
        bus.flush_i: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          pc_q    <= FLUSH_KEEP_PC ? pc_q : '0;
          inst_q  <= NOP_INST;
          cnt_q   <= '0;
        end
        bus.stall_i: begin
          // a stalled bubble stays a bubble
          state_q <= (state_q == EMPTY) ? EMPTY : HELD;
          cnt_q   <= cnt_inc;
          if (cnt_inc == LIMIT)
            to_q <= 1'b1;
        end
        default: begin
          state_q <= bus.valid_i ? FULL : EMPTY;
          valid_q <= bus.valid_i;
          pc_q    <= bus.pc_i;
          inst_q  <= bus.inst_i;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.valid_o         = valid_q;
  assign bus.pc_o            = pc_q;
  assign bus.inst_o          = inst_q;
  assign bus.op_o            = inst_q[31:26];
  assign bus.rs_o            = inst_q[25:21];
  assign bus.rt_o            = inst_q[20:16];
  assign bus.rd_o            = inst_q[15:11];
  assign bus.shamt_o         = inst_q[10:6];
  assign bus.funct_o         = inst_q[5:0];
  assign bus.imm_o           = inst_q[15:0];
  assign bus.jaddr_o         = inst_q[25:0];
  assign bus.held_o          = (state_q == HELD);
  assign bus.stall_cnt_o     = cnt_q;
  assign bus.stall_timeout_o = to_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for the IF/ID pipeline register: a reference model
// queues the expected register contents for every driven edge.
module tb_if_id_stage_reg;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  cnt;
    logic        to;
    logic        held;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t m;

  if_id_stage_reg_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  if_id_stage_reg #(
    .ADDR_W(ADDR_W),
    .NOP_INST(NOP),
    .STALL_LIMIT(15),
    .CNT_W(CNT_W),
    .FLUSH_KEEP_PC(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model of one clock edge
  task automatic model(input logic r, input logic s, input logic f,
                       input logic v, input logic [31:0] p,
                       input logic [31:0] i);
    if (r) begin
      m = '{valid: 1'b0, pc: '0, inst: NOP, cnt: '0, to: 1'b0, held: 1'b0};
    end else if (f) begin
      m.valid = 1'b0;
      m.inst  = NOP;
      m.cnt   = '0;
      m.held  = 1'b0;
    end else if (s) begin
      if (m.cnt != 4'hf) m.cnt = m.cnt + 4'd1;
      if (m.cnt == 4'd15) m.to = 1'b1;
      m.held = m.valid;
    end else begin
      m.valid = v;
      m.pc    = p;
      m.inst  = i;
      m.cnt   = '0;
      m.held  = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f,
                      input logic v, input logic [31:0] p,
                      input logic [31:0] i);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.stall_i = s;
    bus.flush_i = f;
    bus.valid_i = v;
    bus.pc_i    = p;
    bus.inst_i  = i;
    model(r, s, f, v, p, i);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("valid", 64'(bus.valid_o), 64'(e.valid));
      chk("pc", 64'(bus.pc_o), 64'(e.pc));
      chk("inst", 64'(bus.inst_o), 64'(e.inst));
      chk("op", 64'(bus.op_o), 64'(e.inst[31:26]));
      chk("rs", 64'(bus.rs_o), 64'(e.inst[25:21]));
      chk("rt", 64'(bus.rt_o), 64'(e.inst[20:16]));
      chk("rd", 64'(bus.rd_o), 64'(e.inst[15:11]));
      chk("shamt", 64'(bus.shamt_o), 64'(e.inst[10:6]));
      chk("funct", 64'(bus.funct_o), 64'(e.inst[5:0]));
      chk("imm", 64'(bus.imm_o), 64'(e.inst[15:0]));
      chk("jaddr", 64'(bus.jaddr_o), 64'(e.inst[25:0]));
      chk("cnt", 64'(bus.stall_cnt_o), 64'(e.cnt));
      chk("timeout", 64'(bus.stall_timeout_o), 64'(e.to));
      chk("held", 64'(bus.held_o), 64'(e.held));
    end
  endtask

  initial begin
    m = '{valid: 1'b0, pc: '0, inst: NOP, cnt: '0, to: 1'b0, held: 1'b0};
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.pc_i    = '0;
    bus.inst_i  = '0;

    step(1, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_inst", 64'(bus.inst_o), 64'd0);
    chk("rst_pc", 64'(bus.pc_o), 64'd0);
    chk("rst_to", 64'(bus.stall_timeout_o), 64'd0);

    step(0, 0, 0, 1, 32'h40, 32'h8C220004);
    chk("ld_op", 64'(bus.op_o), 64'h23);
    chk("ld_rs", 64'(bus.rs_o), 64'd1);
    chk("ld_rt", 64'(bus.rt_o), 64'd2);
    chk("ld_imm", 64'(bus.imm_o), 64'h4);
    chk("ld_valid", 64'(bus.valid_o), 64'd1);

    for (int k = 0; k < 3; k++)
      step(0, 1, 0, 1, 32'h100 + 32'(k), 32'hDEAD0000 + 32'(k));
    chk("st_pc", 64'(bus.pc_o), 64'h40);
    chk("st_inst", 64'(bus.inst_o), 64'h8C220004);
    chk("st_cnt", 64'(bus.stall_cnt_o), 64'd3);
    chk("st_held", 64'(bus.held_o), 64'd1);

    step(0, 1, 1, 1, 32'h200, 32'h12345678);
    chk("fl_inst", 64'(bus.inst_o), 64'(NOP));
    chk("fl_valid", 64'(bus.valid_o), 64'd0);
    chk("fl_cnt", 64'(bus.stall_cnt_o), 64'd0);
    chk("fl_pc", 64'(bus.pc_o), 64'h40);

    step(0, 0, 0, 1, 32'h44, 32'h00851020);
    for (int k = 0; k < 14; k++)
      step(0, 1, 0, 0, 32'h0, 32'h0);
    chk("wd_14", 64'(bus.stall_timeout_o), 64'd0);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    chk("wd_15", 64'(bus.stall_timeout_o), 64'd1);
    step(0, 0, 0, 1, 32'h48, 32'h08000010);
    chk("wd_sticky", 64'(bus.stall_timeout_o), 64'd1);

    for (int k = 0; k < 20; k++)
      step(0, 1, 0, 1, 32'h0, 32'h0);
    chk("sat_cnt", 64'(bus.stall_cnt_o), 64'd15);

    step(1, 1, 0, 1, 32'h0, 32'h0);
    chk("rh_held", 64'(bus.held_o), 64'd0);
    chk("rh_cnt", 64'(bus.stall_cnt_o), 64'd0);
    chk("rh_to", 64'(bus.stall_timeout_o), 64'd0);

    step(0, 1, 0, 1, 32'h50, 32'h0);
    chk("empty_held", 64'(bus.held_o), 64'd0);

    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 9) == 0), 1'($urandom), $urandom, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
